// File: rtl/etc1_block_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : etc1_pkg
// Description : Shared definitions for the ETC1 block streamer: palette-word
//               field positions, the modifier table and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package etc1_pkg;

    // Palette word (block[63:32]) field positions
    localparam int C_FLIP_BIT    = 0;
    localparam int C_DIFF_BIT    = 1;
    localparam int C_CW0_LSB     = 5;   // codeword for sub-block 0 at [7:5]
    localparam int C_CW1_LSB     = 2;   // codeword for sub-block 1 at [4:2]
    localparam int C_BASE_R_HI   = 31;  // red base field MSB; G and B follow
    localparam int C_CH_STRIDE   = 8;   // distance between channel fields
    localparam int C_IDX_MSB_OFS = 16;  // index MSB plane offset in block[31:0]

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Modifier for a table codeword and a 2-bit index {MSB,LSB}:
    // 00 -> +a, 01 -> +b, 10 -> -a, 11 -> -b
    function automatic logic signed [8:0] etc1_modifier(
        input logic [2:0] cw,
        input logic [1:0] idx
    );
        logic signed [8:0] a;
        logic signed [8:0] b;
        case (cw)
            3'd0:    begin a = 9'sd2;  b = 9'sd8;   end
            3'd1:    begin a = 9'sd5;  b = 9'sd17;  end
            3'd2:    begin a = 9'sd9;  b = 9'sd29;  end
            3'd3:    begin a = 9'sd13; b = 9'sd42;  end
            3'd4:    begin a = 9'sd18; b = 9'sd60;  end
            3'd5:    begin a = 9'sd24; b = 9'sd80;  end
            3'd6:    begin a = 9'sd33; b = 9'sd106; end
            default: begin a = 9'sd47; b = 9'sd183; end
        endcase
        case (idx)
            2'b00:   etc1_modifier = a;
            2'b01:   etc1_modifier = b;
            2'b10:   etc1_modifier = -a;
            default: etc1_modifier = -b;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/etc1_block_stream_texel.sv
`default_nettype none
// ============================================================================
// Module      : etc1_texel
// Description : Combinational decode of one ETC1 texel.
//   i_palette  [31:0] palette word of the block
//   i_indices  [31:0] index planes (LSB plane [15:0], MSB plane [31:16])
//   i_x, i_y   [1:0]  texel coordinate inside the 4x4 block
//   o_rgb      [23:0] decoded {R,G,B}
// Revision    : 1.0 - initial release
// ============================================================================
module etc1_texel
    import etc1_pkg::*;
(
    input  logic [31:0] i_palette,
    input  logic [31:0] i_indices,
    input  logic [1:0]  i_x,
    input  logic [1:0]  i_y,
    output logic [23:0] o_rgb
);

    logic              w_flip;
    logic              w_diff;
    logic              w_sub;
    logic [2:0]        w_cw;
    logic [3:0]        w_pos;
    logic [1:0]        w_idx;
    logic signed [8:0] w_mod;

    assign w_flip = i_palette[C_FLIP_BIT];
    assign w_diff = i_palette[C_DIFF_BIT];
    // Flip splits the block into top/bottom halves, otherwise left/right
    assign w_sub  = w_flip ? i_y[1] : i_x[1];
    assign w_cw   = w_sub ? i_palette[C_CW1_LSB +: 3] : i_palette[C_CW0_LSB +: 3];
    // Index planes are stored column-major: bit position 4x + y
    assign w_pos  = {i_x, i_y};
    assign w_idx  = {i_indices[{1'b1, w_pos}], i_indices[{1'b0, w_pos}]};
    assign w_mod  = etc1_modifier(w_cw, w_idx);

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        localparam int c_HI = C_BASE_R_HI - ch * C_CH_STRIDE;

        logic [4:0]        w_b0_5;
        logic [2:0]        w_delta;
        logic [4:0]        w_b1_5;
        logic [4:0]        w_sel5;
        logic [3:0]        w_nib;
        logic [7:0]        w_base;
        logic signed [9:0] w_sum;

        // Differential mode: 5-bit base plus 3-bit signed delta, mod 32
        assign w_b0_5  = i_palette[c_HI -: 5];
        assign w_delta = i_palette[c_HI - 5 -: 3];
        assign w_b1_5  = w_b0_5 + {{2{w_delta[2]}}, w_delta};
        assign w_sel5  = w_sub ? w_b1_5 : w_b0_5;
        // Individual mode: two independent 4-bit bases
        assign w_nib   = w_sub ? i_palette[c_HI - 4 -: 4] : i_palette[c_HI -: 4];
        assign w_base  = w_diff ? {w_sel5, w_sel5[4:2]} : {w_nib, w_nib};

        // One extra bit of headroom so 255 + 183 cannot wrap before clamping
        assign w_sum = $signed({2'b00, w_base}) + $signed({w_mod[8], w_mod});

        assign o_rgb[23 - ch * 8 -: 8] = w_sum[9] ? 8'h00 :
                                         w_sum[8] ? 8'hFF : w_sum[7:0];
    end

endmodule
`default_nettype wire

// File: rtl/etc1_block_stream.sv
`default_nettype none
// ============================================================================
// Module      : etc1_block_stream
// Description : Accepts one 64-bit ETC1 block per transaction and streams its
//               16 decoded RGB888 texels as LANES texels per beat.
//   clk, reset  clock, synchronous active-high reset
//   in_valid / in_ready / in_block   block input handshake
//   out_valid / out_ready            beat output handshake
//   out_pixels  lane l at [24l+23:24l], {R,G,B}
//   out_x/out_y coordinate of lane 0; out_last marks the final beat
//   blocks_done completed-block counter (only with ETC1_BLOCK_STREAM_COUNT_EN)
// Parameters  : LANES (1,2,4), COL_MAJOR (0 row-major, 1 column-major)
// Options     : `define ETC1_BLOCK_STREAM_COUNT_EN adds blocks_done[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
module etc1_block_stream
    import etc1_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int COL_MAJOR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [63:0]           in_block,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [24*LANES-1:0]   out_pixels,
    output logic [1:0]            out_x,
    output logic [1:0]            out_y,
    output logic                  out_last
`ifdef ETC1_BLOCK_STREAM_COUNT_EN
    ,
    output logic [31:0]           blocks_done
`endif
);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("etc1_block_stream: LANES must be 1, 2 or 4");
    end

    localparam int         c_NBEATS    = 16 / LANES;
    localparam logic [3:0] c_LAST_BEAT = 4'(c_NBEATS - 1);
    localparam logic [3:0] c_LANES4    = 4'(LANES);

    state_t                r_state;
    logic [63:0]           r_block;
    logic [3:0]            r_beat;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [24*LANES-1:0]   r_out_pixels;
    logic [1:0]            r_out_x;
    logic [1:0]            r_out_y;

    logic                  w_out_fire;
    logic                  w_last_fire;
    logic                  w_accept;
    logic                  w_load;
    logic [63:0]           w_src_block;
    logic [3:0]            w_next_beat;
    logic [24*LANES-1:0]   w_pixels;
    logic [1:0]            w_lane_x [LANES];
    logic [1:0]            w_lane_y [LANES];

    assign w_out_fire  = r_out_valid && out_ready;
    assign w_last_fire = w_out_fire && r_out_last;
    assign in_ready    = (r_state == ST_IDLE) || w_last_fire;
    assign w_accept    = in_valid && in_ready;
    // A new beat is loaded either from a freshly accepted block or by
    // advancing within the current one
    assign w_load      = w_accept || (w_out_fire && !r_out_last);
    assign w_src_block = w_accept ? in_block : r_block;
    assign w_next_beat = w_accept ? 4'd0 : r_beat + 4'd1;

    // Decoders look at the beat about to be loaded so results can be
    // registered straight into the output stage
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [3:0] c_LANE = 4'(l);
        logic [3:0] w_t;

        assign w_t         = 4'(w_next_beat * c_LANES4) + c_LANE;
        assign w_lane_x[l] = (COL_MAJOR != 0) ? w_t[3:2] : w_t[1:0];
        assign w_lane_y[l] = (COL_MAJOR != 0) ? w_t[1:0] : w_t[3:2];

        etc1_texel u_texel (
            .i_palette (w_src_block[63:32]),
            .i_indices (w_src_block[31:0]),
            .i_x       (w_lane_x[l]),
            .i_y       (w_lane_y[l]),
            .o_rgb     (w_pixels[24*l +: 24])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_block      <= '0;
            r_beat       <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_pixels <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_STREAM: begin
                    if (w_load) begin
                        r_state      <= ST_STREAM;
                        r_block      <= w_src_block;
                        r_beat       <= w_next_beat;
                        r_out_valid  <= 1'b1;
                        r_out_last   <= (w_next_beat == c_LAST_BEAT);
                        r_out_pixels <= w_pixels;
                        r_out_x      <= w_lane_x[0];
                        r_out_y      <= w_lane_y[0];
                    end else if (w_last_fire) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_pixels = r_out_pixels;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;

`ifdef ETC1_BLOCK_STREAM_COUNT_EN
    logic [31:0] r_blocks_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blocks_done <= '0;
        end else if (w_last_fire) begin
            r_blocks_done <= r_blocks_done + 32'd1;
        end
    end

    assign blocks_done = r_blocks_done;
`endif

endmodule
`default_nettype wire
